// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: state encoding, default widths and
// the constant branch/jump target tables indexed by the decoder's TargSel.
package fetch_unit_pkg;

    localparam int PC_W_DEF = 10;
    localparam int CT_W_DEF = 16;
    localparam int ABS_W    = 16;
    localparam int REL_W    = 8;
    localparam int LUT_N    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Absolute branch targets; wider than any sensible PC so a narrower PC just truncates.
    localparam logic [ABS_W-1:0] LUT_ABS [LUT_N] = '{
        16'd100, 16'd200, 16'd300, 16'd400
    };

    // Signed relative jump offsets, sign-extended to the PC width at use.
    localparam logic signed [REL_W-1:0] LUT_REL [LUT_N] = '{
        8'sd5, -8'sd4, 8'sd16, -8'sd2
    };

endpackage

// File: rtl/fetch_unit_targ_lut.sv
// Combinational target lookup: maps TargSel to an absolute branch target and
// a sign-extended relative jump offset, both at the program counter width.
module targ_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [1:0]      targ_sel_i,
    output logic [PC_W-1:0] abs_targ_o,
    output logic [PC_W-1:0] rel_off_o
);

    logic signed [REL_W-1:0] rel_raw;

    always_comb begin
        rel_raw    = LUT_REL[targ_sel_i];
        abs_targ_o = PC_W'(LUT_ABS[targ_sel_i]);
        // Size cast of a signed operand sign-extends, giving modulo-2^PC_W add semantics.
        rel_off_o  = PC_W'(rel_raw);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the ROM address, counts retired
// instructions (saturating) and halts on the program-done instruction.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | PC parked at 0, counter held, waiting for Start
//   ST_RUN  | one instruction retires per cycle, next PC from decoder
//   ST_HALT | Done high, PC and counter frozen until Start
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int CT_W = CT_W_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Jump,
    input  logic            BranchEn,
    input  logic            Zero,
    input  logic [1:0]      TargSel,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Done,
    output logic [CT_W-1:0] InstCt
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CT_W-1:0] ct_q, ct_d;
    logic            done_q, done_d;

    logic [PC_W-1:0] abs_targ;
    logic [PC_W-1:0] rel_off;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_rel;
    logic [CT_W-1:0] ct_inc;

    targ_lut #(
        .PC_W (PC_W)
    ) u_targ_lut (
        .targ_sel_i (TargSel),
        .abs_targ_o (abs_targ),
        .rel_off_o  (rel_off)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ct_d    = ct_q;
        pc_seq  = pc_q + PC_W'(1);
        pc_rel  = pc_q + rel_off;
        ct_inc  = (ct_q == '1) ? ct_q : ct_q + CT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = ST_RUN;
                    ct_d    = '0;
                end
            end
            ST_RUN: begin
                // Start restarts the program and masks every decoder flag this cycle.
                if (Start) begin
                    pc_d = '0;
                    ct_d = '0;
                end else begin
                    ct_d = ct_inc;
                    if (Ack) begin
                        state_d = ST_HALT;
                    end else if (BranchEn) begin
                        pc_d = abs_targ;
                    end else if (Jump && Zero) begin
                        pc_d = pc_rel;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    ct_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                ct_d    = '0;
            end
        endcase

        done_d = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign ProgCtr = pc_q;
    assign Done    = done_q;
    assign InstCt  = ct_q;

endmodule
